// File: rtl/brq_pkg.sv
// Shared types and limits for the instruction-fetch responder.
package brq_pkg;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } instr_rsp_t;

    localparam int unsigned INSTR_RSP_MAX_LAT = 4;

endpackage

// File: rtl/brq_instr_rsp_pipe.sv
// Fixed-length delay line carrying fetch responses; only the valid bits are reset.
module brq_instr_rsp_pipe
    import brq_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       valid_i,
    input  instr_rsp_t rsp_i,
    output logic       valid_o,
    output instr_rsp_t rsp_o
);

    logic [Depth-1:0] valid_q;
    instr_rsp_t       rsp_q [Depth];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            for (int i = 1; i < int'(Depth); i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Payload needs no reset: it is never observed without its valid bit.
    always_ff @(posedge clk_i) begin
        rsp_q[0] <= rsp_i;
        for (int i = 1; i < int'(Depth); i++) begin
            rsp_q[i] <= rsp_q[i-1];
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign rsp_o   = rsp_q[Depth-1];

endmodule

// File: rtl/brq_instr_mem_responder.sv
// Instruction-fetch bus responder in front of a 1-cycle-latency SRAM: grant gating,
// range check, in-order fixed-latency responses and an in-flight counter.
module brq_instr_mem_responder
    import brq_pkg::*;
#(
    parameter logic [31:0] MemBase        = 32'h0000_0000,
    parameter int unsigned MemDepth       = 1024,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        instr_req_i,
    input  logic [31:0]                 instr_addr_i,
    output logic                        instr_gnt_o,
    output logic                        instr_rvalid_o,
    output logic [31:0]                 instr_rdata_o,
    output logic                        instr_err_o,
    input  logic                        gnt_stall_i,
    output logic                        sram_req_o,
    output logic [$clog2(MemDepth)-1:0] sram_addr_o,
    input  logic [31:0]                 sram_rdata_i,
    output logic [2:0]                  outstanding_o
);

    localparam int unsigned AddrW    = $clog2(MemDepth);
    localparam logic [32:0] MemBytes = 33'(MemDepth) * 33'd4;
    localparam logic [2:0]  MaxOut   = 3'(MaxOutstanding);

    if (RespLatency < 1 || RespLatency > INSTR_RSP_MAX_LAT) begin : g_bad_latency
        $error("RespLatency out of range");
    end
    if (MaxOutstanding < 1 || MaxOutstanding > RespLatency + 1) begin : g_bad_outstanding
        $error("MaxOutstanding out of range");
    end
    if (MemDepth < 2 || (MemDepth & (MemDepth - 1)) != 0) begin : g_bad_depth
        $error("MemDepth must be a power of two >= 2");
    end

    logic [31:0] off;
    logic        in_range;
    logic [2:0]  outstanding_q;
    logic        s1_valid_q;
    logic        s1_err_q;
    instr_rsp_t  s1_rsp;
    logic        rsp_valid;
    instr_rsp_t  rsp;
    instr_rsp_t  hold_q;

    // Grant looks only at the registered count, so rvalid never feeds back into gnt.
    always_comb begin
        off         = instr_addr_i - MemBase;
        in_range    = {1'b0, off} < MemBytes;
        instr_gnt_o = rst_ni & instr_req_i & ~gnt_stall_i & (outstanding_q < MaxOut);
        sram_req_o  = instr_gnt_o & in_range;
        sram_addr_o = off[AddrW+1:2];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= instr_gnt_o;
            s1_err_q   <= ~in_range;
        end
    end

    // SRAM data arrives in the stage-1 cycle, so stage 1 merges it combinationally.
    always_comb begin
        s1_rsp.err   = s1_err_q;
        s1_rsp.rdata = s1_err_q ? 32'h0 : sram_rdata_i;
    end

    if (RespLatency > 1) begin : g_pipe
        brq_instr_rsp_pipe #(
            .Depth (RespLatency - 1)
        ) u_rsp_pipe (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .valid_i (s1_valid_q),
            .rsp_i   (s1_rsp),
            .valid_o (rsp_valid),
            .rsp_o   (rsp)
        );
    end else begin : g_no_pipe
        assign rsp_valid = s1_valid_q;
        assign rsp       = s1_rsp;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_q <= '0;
        end else if (rsp_valid) begin
            hold_q <= rsp;
        end
    end

    always_comb begin
        instr_rvalid_o = rsp_valid;
        instr_rdata_o  = rsp_valid ? rsp.rdata : hold_q.rdata;
        instr_err_o    = rsp_valid ? rsp.err : hold_q.err;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            case ({instr_gnt_o, rsp_valid})
                2'b10:   outstanding_q <= outstanding_q + 3'd1;
                2'b01:   outstanding_q <= outstanding_q - 3'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign outstanding_o = outstanding_q;

`ifndef SYNTHESIS
    a_addr_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (instr_req_i && !instr_gnt_o) |=> $stable(instr_addr_i));
    a_max_outstanding : assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding_q <= MaxOut);
    a_rvalid_needs_outstanding : assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_valid |-> (outstanding_q != 3'd0));
`endif

endmodule
